// File: rtl/prio_pkg.sv
// prio_pkg: shared mode constants, FSM state type and index-width helper for prio_grant_enc
package prio_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/prio_grant_enc_if.sv
// prio_grant_enc_if: request/sample bundle in, registered grant with valid/ack out
interface prio_grant_enc_if import prio_pkg::*; #(parameter int N = 8);
  localparam int W = clog2_min1(N);
  logic mode;
  logic [N-1:0] req;
  logic en;
  logic [W-1:0] idx;
  logic valid;
  logic ack;
  modport master(output mode, req, en, ack, input idx, valid);
  modport slave(input mode, req, en, ack, output idx, valid);
endinterface

// File: rtl/prio_find_msb.sv
// prio_find_msb: combinational highest-set-bit finder
module prio_find_msb #(parameter int N = 8, parameter int W = 3) (
  input  logic [N-1:0] v,
  output logic         found,
  output logic [W-1:0] pos
);
  always_comb begin
    found = 1'b0;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        found = 1'b1;
        pos = W'(i);
      end
    end
  end
endmodule

// File: rtl/prio_grant_enc.sv
// prio_grant_enc: registered fixed/round-robin priority encoder with hold-until-ack grant
module prio_grant_enc import prio_pkg::*; #(parameter int N = 8) (
  input logic clk,
  input logic rst,
  prio_grant_enc_if.slave bus
);
  localparam int W = clog2_min1(N);
  state_t r_state, w_nstate;
  logic [W-1:0] r_idx, r_ptr, w_nidx, w_nptr;
  logic [N-1:0] w_rot;
  logic w_fix_found, w_rr_found, w_found, w_cap;
  logic [W-1:0] w_fix_pos, w_rr_pos, w_rr_win, w_win;
  logic [W:0] w_sum;
  // rotate so req[ptr] lands on the top bit; the msb search then walks ptr downward with wrap
  assign w_rot = N'({bus.req, bus.req} >> ({1'b0, r_ptr} + 1'b1));
  prio_find_msb #(.N(N), .W(W)) u_fix (.v(bus.req), .found(w_fix_found), .pos(w_fix_pos));
  prio_find_msb #(.N(N), .W(W)) u_rr (.v(w_rot), .found(w_rr_found), .pos(w_rr_pos));
  assign w_sum = {1'b0, r_ptr} + {1'b0, w_rr_pos} + 1'b1;
  assign w_rr_win = W'(w_sum >= (W+1)'(N) ? w_sum - (W+1)'(N) : w_sum);
  assign w_win = (bus.mode == MODE_RR) ? w_rr_win : w_fix_pos;
  assign w_found = (bus.mode == MODE_RR) ? w_rr_found : w_fix_found;
  assign w_cap = bus.en & ((r_state == EMPTY) | bus.ack);
  always_comb begin
    w_nstate = r_state;
    w_nidx = r_idx;
    w_nptr = r_ptr;
    w_nstate = w_cap ? (w_found ? HOLD : EMPTY) : ((r_state == HOLD) && bus.ack) ? EMPTY : r_state;
    w_nidx = (w_cap && w_found) ? w_win : r_idx;
    w_nptr = (w_cap && w_found) ? ((w_win == '0) ? W'(N-1) : w_win - 1'b1) : r_ptr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_idx <= '0;
      r_ptr <= W'(N-1);
    end else begin
      r_state <= w_nstate;
      r_idx <= w_nidx;
      r_ptr <= w_nptr;
    end
  end
  assign bus.idx = r_idx;
  assign bus.valid = (r_state == HOLD);
endmodule

// File: tb/tb_prio_grant_enc.sv
// tb_prio_grant_enc: directed + random checks of N=4/5/8 encoders against a behavioural model
module tb_prio_grant_enc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int nn [3] = '{4, 5, 8};
  int m_idx [3];
  int m_ptr [3];
  bit m_valid [3];
  prio_grant_enc_if #(.N(4)) b4();
  prio_grant_enc_if #(.N(5)) b5();
  prio_grant_enc_if #(.N(8)) b8();
  prio_grant_enc #(.N(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  prio_grant_enc #(.N(5)) u5 (.clk(clk), .rst(rst), .bus(b5));
  prio_grant_enc #(.N(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int winner(input int n, input bit rr, input logic [31:0] q, input int ptr);
    int w = -1;
    for (int s = 0; s < n; s++) begin
      int k = rr ? (ptr - s + n) % n : n - 1 - s;
      if (w < 0 && q[k]) w = k;
    end
    return w;
  endfunction
  task automatic step(input bit r, input bit m, input logic [31:0] q, input bit e, input bit a);
    rst = r;
    b4.mode = m; b4.req = q[3:0]; b4.en = e; b4.ack = a;
    b5.mode = m; b5.req = q[4:0]; b5.en = e; b5.ack = a;
    b8.mode = m; b8.req = q[7:0]; b8.en = e; b8.ack = a;
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      int n = nn[d];
      logic [31:0] qm = q & ((32'd1 << n) - 1);
      if (r) begin
        m_valid[d] = 0; m_idx[d] = 0; m_ptr[d] = n - 1;
      end else if (e && (!m_valid[d] || a)) begin
        int w = winner(n, m, qm, m_ptr[d]);
        if (w >= 0) begin
          m_idx[d] = w; m_valid[d] = 1; m_ptr[d] = (w == 0) ? n - 1 : w - 1;
        end else m_valid[d] = 0;
      end else if (m_valid[d] && a) m_valid[d] = 0;
    end
    #1;
    check("n4_valid", int'(b4.valid), int'(m_valid[0]));
    check("n4_idx", int'(b4.idx), m_idx[0]);
    check("n5_valid", int'(b5.valid), int'(m_valid[1]));
    check("n5_idx", int'(b5.idx), m_idx[1]);
    check("n8_valid", int'(b8.valid), int'(m_valid[2]));
    check("n8_idx", int'(b8.idx), m_idx[2]);
  endtask
  initial begin
    int fx_req [4] = '{1, 3, 6, 10};
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_valid", int'(b8.valid), 0);
    check("rst_idx", int'(b8.idx), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, fx_req[i], 1, 1);
      check("fix4_valid", int'(b4.valid), 1);
      check("fix4_idx", int'(b4.idx), i);
      step(0, 0, 0, 0, 1);
      check("fix4_clear", int'(b4.valid), 0);
    end
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 'hFF, 1, 1);
      check("rr8_valid", int'(b8.valid), 1);
      check("rr8_idx", int'(b8.idx), (7 - i + 8) % 8);
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 8'b0010_0110, 1, 0);
    check("hold_idx", int'(b8.idx), 5);
    for (int i = 0; i < 5; i++) begin
      step(0, i[0], 'h80, 1, 0);
      check("frozen_idx", int'(b8.idx), 5);
      check("frozen_valid", int'(b8.valid), 1);
    end
    step(0, 0, 'h80, 0, 1);
    check("ack_clear", int'(b8.valid), 0);
    step(0, 0, 0, 1, 0);
    check("zero_valid", int'(b8.valid), 0);
    check("zero_idx", int'(b8.idx), 5);
    step(0, 1, 5'b00001, 1, 1);
    check("rr5_first", int'(b5.idx), 0);
    step(0, 1, 5'b10001, 1, 1);
    check("rr5_wrap", int'(b5.idx), 4);
    step(0, 0, 'h40, 1, 1);
    check("pre_rst_idx", int'(b8.idx), 6);
    step(1, 0, 'h40, 0, 0);
    check("midrst_idx", int'(b8.idx), 0);
    check("midrst_valid", int'(b8.valid), 0);
    step(0, 1, 'hFF, 1, 0);
    check("post_rst_rr", int'(b8.idx), 7);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 49) == 0, 1'($urandom), $urandom & ($urandom | $urandom),
           $urandom_range(0, 9) < 7, 1'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
